// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding for the stopwatch control front-end
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop synchronizer, optional debounce (STOPWATCH_DEBOUNCE_EN), rising-edge press
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);
    logic meta, sync, level, prev;
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= button;
            sync <= meta;
            prev <= level;
        end
    end
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] stable_cnt;
    logic stable;
    // accept a new level only after it has persisted for DEBOUNCE_CYCLES samples
    always_ff @(posedge clock) begin
        if (reset) begin
            stable     <= 1'b0;
            stable_cnt <= '0;
        end else if (sync == stable) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable     <= sync;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
    assign level = stable;
`else
    assign level = sync;
`endif
    assign press = level & ~prev;
endmodule

// File: rtl/stopwatch_control.sv
// stopwatch_control: button-driven IDLE/RUN/PAUSE control issuing count/clear pulses
// Build option: STOPWATCH_DEBOUNCE_EN adds debounce to both button paths.
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIVIDE     = 100,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic button_start,
    input  logic button_clear,
    output logic count,
    output logic clear,
    output logic running
);
    localparam int PW = $clog2(TICK_DIVIDE);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIVIDE - 1);
    state_t state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic start_ev, clear_ev, tick;
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clock(clock), .reset(reset), .button(button_start), .press(start_ev)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clock(clock), .reset(reset), .button(button_clear), .press(clear_ev)
    );
    // prescaler only advances on plain RUN cycles, so a pause keeps the period phase
    always_comb begin
        state_n = clear_ev ? IDLE : start_ev ? (state == RUN ? PAUSE : RUN) : state;
        pre_n   = (clear_ev || state == IDLE) ? '0 :
                  (state == RUN && !start_ev) ? (pre == LAST ? '0 : pre + 1'b1) : pre;
        tick    = state == RUN && pre == LAST && !start_ev && !clear_ev;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pre     <= '0;
            count   <= 1'b0;
            clear   <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            pre     <= pre_n;
            count   <= tick;
            clear   <= clear_ev;
            running <= state_n == RUN;
        end
    end
endmodule
